banked_reg_file: RTL and testbench
==================================

Name: banked_reg_file

Overview:
- Parametrised successor to the fixed 12×8 register file: NUM_BANKS banks of BANK_SIZE registers.
- rs reads the flat address space. rt and rd are bank-relative and use runtime-selectable bank pointers.
- Adds same-cycle write-to-read bypass, asynchronous clear, and a multi-cycle bank-copy engine with busy/done handshake.
- Sits between decode and the ALU in the emulator datapath.

Parameters:
- NUM_BANKS, 3, number of register banks (≥2)
- BANK_SIZE, 4, registers per bank (power of 2, ≥2)
- REG_WIDTH, 8, bits per register
- RT_BANK_RST, 1, rt bank pointer value after reset
- RD_BANK_RST, 2, rd bank pointer value after reset
- Derived: NUM_REG=NUM_BANKS*BANK_SIZE; ADDR_W=$clog2(NUM_REG); OFF_W=$clog2(BANK_SIZE); BANK_W=max(1,$clog2(NUM_BANKS))

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- write  in  1  write enable for rd port
- rs_addr  in  ADDR_W  flat read address
- rt_addr  in  OFF_W  rt offset within rt bank
- rd_addr  in  OFF_W  rd offset within rd bank
- rd_in  in  REG_WIDTH  write data
- rs_out  out  REG_WIDTH  rs read data
- rt_out  out  REG_WIDTH  rt read data
- bank_set  in  1  load rt_bank_in/rd_bank_in into bank pointers
- rt_bank_in  in  BANK_W  new rt bank
- rd_bank_in  in  BANK_W  new rd bank
- rt_bank  out  BANK_W  current rt bank pointer
- rd_bank  out  BANK_W  current rd bank pointer
- copy_start  in  1  request bank copy
- copy_src  in  BANK_W  source bank
- copy_dst  in  BANK_W  destination bank
- copy_busy  out  1  copy in progress
- copy_done  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: all registers 0; rt_bank=RT_BANK_RST; rd_bank=RD_BANK_RST; FSM→IDLE; copy_busy=0; copy_done=0. Reset mid-copy aborts the copy with no partial-completion pulse.
- Effective addresses: rt_eff=rt_bank*BANK_SIZE+rt_addr; rd_eff=rd_bank*BANK_SIZE+rd_addr. Computed at ADDR_W bits, no wrap.
- Reads are combinational.
  - If write=1 and rd_eff equals the read address, the port returns rd_in (bypass).
  - Otherwise the port returns the array value.
  - rs_addr≥NUM_REG reads 0.
- Write: on posedge, if write=1, regs[rd_eff]<=rd_in using the pre-edge rd_bank.
- bank_set: pointers update at the edge. Reads and writes in the same cycle use the old pointers.
  - If a bank value is ≥NUM_BANKS, that pointer is unchanged; the other pointer still loads.
- Copy FSM states: IDLE, COPY, DONE.
  - IDLE→COPY on copy_start=1 with both src and dst <NUM_BANKS. Latches src and dst; idx=0. Otherwise stays IDLE; invalid requests are dropped.
  - COPY, each cycle: regs[dst*BANK_SIZE+idx]<=regs[src*BANK_SIZE+idx] (pre-edge array value, no bypass); idx++. When idx==BANK_SIZE-1, go to DONE.
  - DONE: copy_done=1 for one cycle, then →IDLE.
  - copy_busy=1 exactly in COPY.
  - copy_start is ignored outside IDLE.
  - Latency: start sampled at edge N; copy_done high in cycle N+BANK_SIZE+1.
- Simultaneous events:
  - Port write and copy write to the same register: the port write wins.
  - Port write to a source register: the copy takes the old value if that index is copied the same cycle.
  - src==dst: full sequence runs, contents unchanged.
  - bank_set during a copy is allowed and does not affect latched src/dst.
- Outputs copy_busy, copy_done, rt_bank and rd_bank are registered. rs_out and rt_out are combinational.

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic [1:0] {IDLE, COPY, DONE} copy_state_t
  - width-helper functions for ADDR_W, OFF_W and BANK_W
- Sub-module rf_copy_ctrl contains the FSM, idx counter and latched src/dst. Outputs: copy write enable, source address, destination address, busy, done.
- The top level holds the array, the bank pointers, the write-priority mux and the bypass.

Test Plan:
- Reset: assert reset mid-cycle → rs_out=0 for all rs_addr 0..15; rt_bank=1, rd_bank=2; copy_busy=0.
- Write/read mapping: write=1, rd_addr=3, rd_in=0xA5 → same cycle rt_addr=3 gives rt_out=0xA5 only when rt_bank=2, else bypass off. Next cycle rs_addr=11 gives 0xA5. rs_addr=12..15 reads 0.
- Bank switch: bank_set with rt_bank_in=2, rd_bank_in=0 and write rd_addr=1, data 0x3C in the same cycle → 0x3C lands in reg 9, not reg 1. Next cycle rt_addr=1 reads 0x3C.
- Copy: fill bank 2 with 0x10..0x13; copy_start src=2 dst=0 → copy_busy high for 4 cycles, copy_done pulses in cycle 5; rs_addr 0..3 read 0x10..0x13.
- Copy conflict: during copy of 2→0, port write to reg 1 with 0xFF in the cycle idx=1 → reg 1=0xFF after copy. Also a copy_start while busy is ignored; no second done pulse.
- Reset mid-copy: assert reset at idx=2 → copy_done never pulses, all regs 0, FSM IDLE. A new copy_start is accepted on the first edge after deassertion.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared FSM state type and width helpers for the banked register file.
package rf_pkg;

    typedef enum logic [1:0] {IDLE, COPY, DONE} copy_state_t;

    function automatic int addr_w(input int num_banks, input int bank_size);
        return $clog2(num_banks * bank_size);
    endfunction

    function automatic int off_w(input int bank_size);
        return $clog2(bank_size);
    endfunction

    function automatic int bank_w(input int num_banks);
        return ($clog2(num_banks) > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/rf_copy_ctrl.sv
// Bank-copy sequencer: one register per cycle, BANK_SIZE cycles busy, then a one-cycle done.
// Requests are accepted only in IDLE and only with in-range banks; others are dropped, no backpressure.
module rf_copy_ctrl
    import rf_pkg::*;
#(
    parameter int NUM_BANKS = 3,
    parameter int BANK_SIZE = 4,
    parameter int ADDR_W    = 4,
    parameter int OFF_W     = 2,
    parameter int BANK_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [BANK_W-1:0] src_i,
    input  logic [BANK_W-1:0] dst_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BANK_SIZE - 1);

    copy_state_t       state_q;
    logic [OFF_W-1:0]  idx_q;
    logic [BANK_W-1:0] src_q;
    logic [BANK_W-1:0] dst_q;
    logic              busy_q;
    logic              done_q;
    logic              req_ok;

    assign req_ok = (int'(src_i) < NUM_BANKS) && (int'(dst_i) < NUM_BANKS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && req_ok) begin
                        state_q <= COPY;
                        src_q   <= src_i;
                        dst_q   <= dst_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                COPY: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // BANK_SIZE is a power of two, so bank:offset concatenation is the flat address.
    assign src_addr_o = ADDR_W'({src_q, idx_q});
    assign dst_addr_o = ADDR_W'({dst_q, idx_q});
    assign we_o       = (state_q == COPY);
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/banked_reg_file.sv
// Banked register file: combinational reads with write bypass, one write port, bank-copy engine.
// Reads are zero-latency; writes and pointer updates take effect at the edge; no backpressure.
module banked_reg_file
    import rf_pkg::*;
#(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_SIZE   = 4,
    parameter int REG_WIDTH   = 8,
    parameter int RT_BANK_RST = 1,
    parameter int RD_BANK_RST = 2,
    localparam int NUM_REG    = NUM_BANKS * BANK_SIZE,
    localparam int ADDR_W     = addr_w(NUM_BANKS, BANK_SIZE),
    localparam int OFF_W      = off_w(BANK_SIZE),
    localparam int BANK_W     = bank_w(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [OFF_W-1:0]     rt_addr,
    input  logic [OFF_W-1:0]     rd_addr,
    input  logic [REG_WIDTH-1:0] rd_in,
    output logic [REG_WIDTH-1:0] rs_out,
    output logic [REG_WIDTH-1:0] rt_out,
    input  logic                 bank_set,
    input  logic [BANK_W-1:0]    rt_bank_in,
    input  logic [BANK_W-1:0]    rd_bank_in,
    output logic [BANK_W-1:0]    rt_bank,
    output logic [BANK_W-1:0]    rd_bank,
    input  logic                 copy_start,
    input  logic [BANK_W-1:0]    copy_src,
    input  logic [BANK_W-1:0]    copy_dst,
    output logic                 copy_busy,
    output logic                 copy_done
);

    logic [REG_WIDTH-1:0] regs_q [NUM_REG];
    logic [BANK_W-1:0]    rt_bank_q, rt_bank_d;
    logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]    rt_eff, rd_eff;
    logic [ADDR_W-1:0]    cp_src, cp_dst;
    logic                 cp_we;

    rf_copy_ctrl #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_SIZE (BANK_SIZE),
        .ADDR_W    (ADDR_W),
        .OFF_W     (OFF_W),
        .BANK_W    (BANK_W)
    ) u_copy (
        .clk        (clk),
        .reset      (reset),
        .start_i    (copy_start),
        .src_i      (copy_src),
        .dst_i      (copy_dst),
        .we_o       (cp_we),
        .src_addr_o (cp_src),
        .dst_addr_o (cp_dst),
        .busy_o     (copy_busy),
        .done_o     (copy_done)
    );

    assign rt_eff = ADDR_W'({rt_bank_q, rt_addr});
    assign rd_eff = ADDR_W'({rd_bank_q, rd_addr});

    always_comb begin
        rs_out = '0;
        if (write && (rd_eff == rs_addr)) begin
            rs_out = rd_in;
        end else if (int'(rs_addr) < NUM_REG) begin
            rs_out = regs_q[rs_addr];
        end
    end

    assign rt_out = (write && (rd_eff == rt_eff)) ? rd_in : regs_q[rt_eff];

    // An out-of-range bank value leaves only its own pointer untouched.
    always_comb begin
        rt_bank_d = rt_bank_q;
        rd_bank_d = rd_bank_q;
        if (bank_set && (int'(rt_bank_in) < NUM_BANKS)) rt_bank_d = rt_bank_in;
        if (bank_set && (int'(rd_bank_in) < NUM_BANKS)) rd_bank_d = rd_bank_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rt_bank_q <= BANK_W'(RT_BANK_RST);
            rd_bank_q <= BANK_W'(RD_BANK_RST);
        end else begin
            rt_bank_q <= rt_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Port write is issued last so it overrides a copy write to the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
        end else begin
            if (cp_we) regs_q[cp_dst] <= regs_q[cp_src];
            if (write) regs_q[rd_eff] <= rd_in;
        end
    end

    assign rt_bank = rt_bank_q;
    assign rd_bank = rd_bank_q;

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed scoreboard bench for banked_reg_file with default parameters (3 banks x 4 regs x 8 bits).
`timescale 1ns/1ps
module tb_banked_reg_file;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic [3:0] rs_addr = '0;
    logic [1:0] rt_addr = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_in = '0;
    logic [7:0] rs_out, rt_out;
    logic       bank_set = 1'b0;
    logic [1:0] rt_bank_in = '0;
    logic [1:0] rd_bank_in = '0;
    logic [1:0] rt_bank, rd_bank;
    logic       copy_start = 1'b0;
    logic [1:0] copy_src = '0;
    logic [1:0] copy_dst = '0;
    logic       copy_busy, copy_done;

    banked_reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .rd_in      (rd_in),
        .rs_out     (rs_out),
        .rt_out     (rt_out),
        .bank_set   (bank_set),
        .rt_bank_in (rt_bank_in),
        .rd_bank_in (rd_bank_in),
        .rt_bank    (rt_bank),
        .rd_bank    (rd_bank),
        .copy_start (copy_start),
        .copy_src   (copy_src),
        .copy_dst   (copy_dst),
        .copy_busy  (copy_busy),
        .copy_done  (copy_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            0:       return 32'(rs_out);
            1:       return 32'(rt_out);
            2:       return 32'(rt_bank);
            3:       return 32'(rd_bank);
            4:       return 32'(copy_busy);
            default: return 32'(copy_done);
        endcase
    endfunction

    task automatic expect_o(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val(e.tag, get_out(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_rs(input int a, input logic [31:0] v, input string tag);
        rs_addr = 4'(a);
        expect_o($sformatf("%s_rs%0d", tag, a), 0, v);
        drain();
    endtask

    // Called in the cycle after the start edge; copy_done must appear in the fifth cycle.
    task automatic run_copy_checks(input string tag);
        copy_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_o($sformatf("%s_busy_c%0d", tag, k), 4, 1);
            expect_o($sformatf("%s_done_c%0d", tag, k), 5, 0);
            drain();
            tick();
        end
        expect_o({tag, "_busy_c5"}, 4, 0);
        expect_o({tag, "_done_c5"}, 5, 1);
        drain();
        tick();
        expect_o({tag, "_done_c6"}, 5, 0);
        drain();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, including a reset asserted mid-cycle over a live value.
        #12 reset = 1'b0;
        tick();
        write = 1'b1; rd_addr = 2'd0; rd_in = 8'h77;
        tick();
        write = 1'b0;
        rd_rs(8, 8'h77, "prerst");
        #1 reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            if (a % 4 == 0) tick();
            rd_rs(a, 0, "rst");
        end
        expect_o("rst_rt_bank", 2, 1);
        expect_o("rst_rd_bank", 3, 2);
        expect_o("rst_busy", 4, 0);
        expect_o("rst_done", 5, 0);
        drain();
        tick();
        #3 reset = 1'b0;

        // Write/read mapping and bypass gating by rt bank.
        tick();
        write = 1'b1; rd_addr = 2'd3; rd_in = 8'hA5; rt_addr = 2'd3; rs_addr = 4'd11;
        expect_o("map_rt_nobyp", 1, 0);
        expect_o("map_rs_byp", 0, 8'hA5);
        drain();
        tick();
        write = 1'b0;
        rd_rs(11, 8'hA5, "map");
        expect_o("map_rt_b1", 1, 0);
        drain();
        for (int a = 12; a < 16; a++) rd_rs(a, 0, "oob");

        tick();
        bank_set = 1'b1; rt_bank_in = 2'd2; rd_bank_in = 2'd3;
        tick();
        bank_set = 1'b0;
        expect_o("bset_rt_bank", 2, 2);
        expect_o("bset_rd_invalid", 3, 2);
        drain();
        write = 1'b1; rd_addr = 2'd3; rd_in = 8'h5A; rt_addr = 2'd3;
        expect_o("rt_byp", 1, 8'h5A);
        drain();
        rt_addr = 2'd2;
        expect_o("rt_byp_other", 1, 0);
        drain();
        tick();
        write = 1'b0; rt_addr = 2'd3;
        expect_o("rt_arr", 1, 8'h5A);
        drain();

        // bank_set with a write in the same cycle: the write uses the old rd bank.
        tick();
        bank_set = 1'b1; rt_bank_in = 2'd2; rd_bank_in = 2'd0;
        write = 1'b1; rd_addr = 2'd1; rd_in = 8'h3C;
        tick();
        bank_set = 1'b0; write = 1'b0; rt_addr = 2'd1;
        expect_o("sw_rd_bank", 3, 0);
        expect_o("sw_rt_bank", 2, 2);
        expect_o("sw_rt_out", 1, 8'h3C);
        drain();
        rd_rs(1, 0, "sw");
        rd_rs(9, 8'h3C, "sw");

        // Fill bank 2, then copy it to bank 0.
        tick();
        bank_set = 1'b1; rt_bank_in = 2'd2; rd_bank_in = 2'd2;
        tick();
        bank_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write = 1'b1; rd_addr = 2'(i); rd_in = 8'(8'h10 + i);
            tick();
        end
        write = 1'b0;
        copy_start = 1'b1; copy_src = 2'd2; copy_dst = 2'd0;
        tick();
        run_copy_checks("cp");
        for (int a = 0; a < 4; a++) rd_rs(a, 8'(8'h10 + a), "cp");

        // Copy with a conflicting port write and an ignored restart.
        tick();
        bank_set = 1'b1; rt_bank_in = 2'd0; rd_bank_in = 2'd0;
        copy_start = 1'b1; copy_src = 2'd2; copy_dst = 2'd0;
        tick();
        bank_set = 1'b0;
        copy_src = 2'd0; copy_dst = 2'd1;
        tick();
        copy_start = 1'b0;
        write = 1'b1; rd_addr = 2'd1; rd_in = 8'hFF;
        rd_rs(1, 8'hFF, "cfl_byp");
        tick();
        write = 1'b0;
        expect_o("cfl_busy_i2", 4, 1);
        drain();
        tick();
        tick();
        expect_o("cfl_done", 5, 1);
        drain();
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_o($sformatf("cfl_nodone%0d", k), 5, 0);
            expect_o($sformatf("cfl_idle%0d", k), 4, 0);
            drain();
        end
        rd_rs(0, 8'h10, "cfl");
        rd_rs(1, 8'hFF, "cfl");
        rd_rs(2, 8'h12, "cfl");
        rd_rs(3, 8'h13, "cfl");
        rd_rs(4, 0, "cfl");

        // Reset in the middle of a copy, then restart on the first edge after release.
        tick();
        copy_start = 1'b1; copy_src = 2'd2; copy_dst = 2'd1;
        tick();
        copy_start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        expect_o("mid_busy", 4, 0);
        expect_o("mid_done", 5, 0);
        expect_o("mid_rt_bank", 2, 1);
        expect_o("mid_rd_bank", 3, 2);
        drain();
        rd_rs(4, 0, "mid");
        rd_rs(8, 0, "mid");
        copy_start = 1'b1; copy_src = 2'd2; copy_dst = 2'd1;
        tick();
        expect_o("mid_held_done", 5, 0);
        drain();
        #2 reset = 1'b0;
        tick();
        run_copy_checks("rst_cp");

        // Out-of-range copy request is dropped.
        tick();
        copy_start = 1'b1; copy_src = 2'd3; copy_dst = 2'd0;
        tick();
        copy_start = 1'b0;
        expect_o("bad_req_busy", 4, 0);
        drain();
        tick();
        expect_o("bad_req_done", 5, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
